// File: rtl/rx_to_mem_pkg.sv
// ---------------------------------------------------------------------------
// rx_to_mem_pkg
// Shared definitions for the UART-to-operand-memory loader.
//   state_t         - loader FSM state encoding (2 bits)
//   START_BYTE_DEF  - default header byte that opens a load
//   ADDR_W_DEF      - default operand memory address width
//   TIMEOUT_DEF     - default idle bclk cycles tolerated between payload bytes
// ---------------------------------------------------------------------------
package rx_to_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] START_BYTE_DEF = 8'hA5;
    localparam int         ADDR_W_DEF     = 6;
    localparam int         TIMEOUT_DEF    = 4800;

endpackage

// File: rtl/rx_edge_sync.sv
// ---------------------------------------------------------------------------
// rx_edge_sync
// Three-flop synchroniser on the receiver's rx_valid level, followed by a
// rising-edge detector. A level held high for any number of cycles gives a
// single one-cycle pulse.
// Ports:
//   bclk   in   baud-rate clock
//   rst    in   asynchronous active-high reset
//   din    in   asynchronous level to be synchronised (rx_valid)
//   pulse  out  one-cycle pulse, high while s2 & ~s3
// ---------------------------------------------------------------------------
module rx_edge_sync (
    input  logic bclk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic s1, s2, s3;

    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples its input's pre-edge value; blocking here would collapse the
    // three-stage chain into a single flop.
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/rx_to_mem.sv
// ---------------------------------------------------------------------------
// rx_to_mem
// Upstream loader for the matrix multiplier. Receives framed byte streams
// from the UART receiver (START_BYTE header, then ROWS*COLS bytes of A and
// ROWS*COLS bytes of B, row-major) and issues write strobes to the two
// operand memories. A one-cycle mats_ready pulse starts the multiply.
// Ports:
//   bclk        in   baud-rate clock
//   rst         in   asynchronous active-high reset
//   rx_valid    in   receiver level, high while rx_byte is stable
//   rx_byte     in   received byte
//   rx_err      in   framing error for the current byte
//   wr_a        out  write strobe, memory A
//   wr_b        out  write strobe, memory B
//   wr_addr     out  write address, shared by A and B
//   wr_data     out  write data, shared by A and B
//   busy        out  high while loading A or B
//   mats_ready  out  one-cycle pulse after the last B byte is written
//   err         out  sticky abort flag, cleared by the next accepted header
// ---------------------------------------------------------------------------
module rx_to_mem
    import rx_to_mem_pkg::*;
#(
    parameter int         ROWS       = 2,
    parameter int         COLS       = 2,
    parameter int         ADDR_W     = ADDR_W_DEF,
    parameter logic [7:0] START_BYTE = START_BYTE_DEF,
    parameter int         TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              bclk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              rx_err,
    output logic              wr_a,
    output logic              wr_b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              mats_ready,
    output logic              err
);

    localparam int                N        = ROWS * COLS;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
    localparam int                GAP_W    = $clog2(TIMEOUT + 1);

    // -----------------------------------------------------------------------
    // Byte detect: synchronised rising edge of rx_valid, then byte and error
    // flag captured together so the FSM sees a stable, aligned pair.
    // -----------------------------------------------------------------------
    logic       accept;
    logic       acc_q;
    logic [7:0] byte_q;
    logic       err_q;

    rx_edge_sync u_edge (
        .bclk  (bclk),
        .rst   (rst),
        .din   (rx_valid),
        .pulse (accept)
    );

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            acc_q  <= 1'b0;
            byte_q <= '0;
            err_q  <= 1'b0;
        end else begin
            acc_q <= accept;
            if (accept) begin
                byte_q <= rx_byte;
                err_q  <= rx_err;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM decode
    // -----------------------------------------------------------------------
    state_t            state, next_state;
    logic [ADDR_W-1:0] idx;
    logic [GAP_W-1:0]  gap_cnt;

    logic loading;
    logic timeout_hit;
    logic do_write;
    logic abort;
    logic start_hit;

    assign loading = (state == LOAD_A) || (state == LOAD_B);

    // The abort fires on the edge where the counter would reach TIMEOUT. A
    // byte arriving in that same cycle takes priority and clears the counter.
    assign timeout_hit = loading && !acc_q && (gap_cnt == GAP_W'(TIMEOUT - 1));
    assign do_write    = loading && acc_q && !err_q;
    assign abort       = loading && ((acc_q && err_q) || timeout_hit);
    assign start_hit   = (state == IDLE) && acc_q && !err_q && (byte_q == START_BYTE);

    // NOTE: every signal driven here receives a default before the case so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_hit)
                    next_state = LOAD_A;
            end
            LOAD_A: begin
                if (abort)
                    next_state = IDLE;
                else if (do_write && idx == LAST_IDX)
                    next_state = LOAD_B;
            end
            LOAD_B: begin
                if (abort)
                    next_state = IDLE;
                else if (do_write && idx == LAST_IDX)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Gap counter: counts idle cycles between payload bytes, saturating.
    // -----------------------------------------------------------------------
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (!loading || acc_q) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GAP_W'(TIMEOUT)) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: only the loader's own registers are reset. The operand memories
    // sit downstream and keep their contents across reset; a half-written
    // matrix stays in place until the next complete load overwrites it.
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            wr_a       <= 1'b0;
            wr_b       <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            mats_ready <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= next_state;
            wr_a       <= do_write && (state == LOAD_A);
            wr_b       <= do_write && (state == LOAD_B);
            mats_ready <= (state == DONE);
            busy       <= (next_state == LOAD_A) || (next_state == LOAD_B);

            if (do_write) begin
                wr_addr <= idx;
                wr_data <= byte_q;
            end

            if (start_hit) begin
                err <= 1'b0;
                idx <= '0;
            end else if (abort) begin
                err <= 1'b1;
                idx <= '0;
            end else if (do_write) begin
                // Wrap to 0 after the last element so LOAD_B starts at 0.
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule
